wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order ALU writeback stream and variable-latency load returns from data memory. Sits between the memory stage and the register file, in place of a fixed ALU/mem mux. Buffers load returns in a small queue, keeps a per-register pending-load scoreboard for decode hazard detection, and stalls the ALU writeback stream when it loses arbitration or would violate write-after-write order.

## Interface
Parameters:
- XLEN, 32, data width
- LDQ_DEPTH, 2, load-return queue entries; also the maximum number of outstanding loads
- STARVE_MAX, 4, consecutive ALU wins tolerated while the queue is non-empty

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result presented this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_stall  out  1  ALU result not consumed; upstream holds alu_* stable
- ld_issue_valid  in  1  load issued to memory this cycle
- ld_issue_rd  in  5  destination of the issued load
- ld_issue_ready  out  1  load may issue: outstanding < LDQ_DEPTH and !busy[ld_issue_rd]
- ld_ret_valid  in  1  load data returning; no backpressure
- ld_ret_rd  in  5  returning load destination
- ld_ret_data  in  XLEN  returning load data
- rs1, rs2  in  5 each  decode source registers
- hazard  out  1  busy[rs1] or busy[rs2], with x0 never busy
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data

## Operation
- State:
  - LRQ FIFO of {rd, data}, with head/tail pointers and a count.
  - outstanding counter, 0..LDQ_DEPTH.
  - busy[31:1] scoreboard.
  - starve counter.
- Issue: on ld_issue_valid && ld_issue_ready, outstanding increments. If rd != 0, busy[rd] is set.
- Return: on ld_ret_valid, an entry is enqueued if rd != 0. If rd == 0, the return is dropped and outstanding decrements at once. Overflow cannot occur because issue is credit-limited.
- Arbitration each cycle. Candidates are A = alu_valid && !busy[alu_rd] and L = LRQ non-empty.
  - Load wins if L && (!A || count == LDQ_DEPTH || starve == STARVE_MAX).
  - Otherwise ALU wins if A.
- Grant L:
  - rf_* = head entry, rf_we = 1; dequeue.
  - Clear busy[head.rd]; outstanding decrements; starve = 0.
- Grant ALU: rf_* = ALU fields, rf_we = (alu_rd != 0). starve increments if L, else starve = 0.
- alu_stall = alu_valid && !ALU-granted. This includes the WAW case where busy[alu_rd] is set.
- ALU writes to x0 are consumed without writing.
- Simultaneous events:
  - Issue + dequeue in the same cycle: outstanding is unchanged.
  - Enqueue + dequeue when full: legal. Dequeue frees the slot in the same edge.
  - Set + clear of the same busy bit cannot occur, because ld_issue_ready is low while that register is busy.
- ld_ret_valid while outstanding == 0 is a protocol error and is ignored.

## Timing
- rf_we, rf_waddr, rf_wdata, alu_stall, hazard and ld_issue_ready are combinational from registered state plus the current inputs. The register file writes at the edge ending the grant cycle.
- Load latency: a return sampled at edge N writes no earlier than the cycle after N (rf_we high in cycle N+1).
- ALU latency: 0 when granted, i.e. written at the same edge.
- The busy clear and the RF write happen at the same edge, so hazard deasserts in the first cycle the RF holds the value.
- Maximum ALU stall due to a non-empty queue is STARVE_MAX + LDQ_DEPTH cycles.
- Reset:
  - LRQ empty, outstanding = 0, busy = 0, starve = 0.
  - During reset: rf_we = 0, alu_stall = 0, ld_issue_ready = 0, hazard = 0.
  - Reset mid-operation discards queued and outstanding loads. The memory subsystem is reset on the same edge.

## Structure
- Shared package wb_arb_pkg holds REG_ADDR_W = 5, the XLEN default, and the LRQ entry struct {rd, data}.
- One sub-module, load_return_fifo: parameterised depth, count output, no-overflow assertion.
- The scoreboard, credit counter and arbiter live in the top module.

## Test plan
- Idle ALU stream:
  - Stimulus: alu_valid with rd=5, data=0x1234, no loads.
  - Required: rf_we=1, waddr=5, wdata=0x1234 in the same cycle; alu_stall=0.
- Load round trip:
  - Stimulus: issue rd=7, return 3 cycles later with data 0xDEAD.
  - Required: hazard is high while rs1=7 from the cycle after issue; the write of 0xDEAD to x7 happens the cycle after the return; hazard is low the next cycle.
- Credit limit:
  - Stimulus: two loads outstanding (rd=1, rd=2).
  - Required: ld_issue_ready=0 until the first dequeue, then 1.
- Queue full plus ALU:
  - Stimulus: LRQ full, alu_valid with rd=3.
  - Required: load granted, alu_stall=1; ALU written the following cycle.
- Starvation and WAW:
  - Stimulus: continuous ALU traffic with one queued load.
  - Required: load granted after exactly 4 ALU wins.
  - Stimulus: ALU rd equal to a pending load's rd.
  - Required: alu_stall holds until that load writes.
- x0 and reset:
  - Stimulus: load to x0.
  - Required: no write, credit returned.
  - Stimulus: reset with two loads outstanding.
  - Required: ld_issue_ready=1 and hazard=0 one cycle after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN_DEF   = 32;

  // Load-return queue entry at the default data width.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } lrq_entry_t;

  // Which source owns the write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LOAD = 2'd2
  } grant_e;

endpackage

// File: rtl/load_return_fifo.sv
// Small circular FIFO holding returned loads until they win the write port.
module load_return_fifo
  import wb_arb_pkg::*;
#(
  parameter type         entry_t = lrq_entry_t,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  entry_t           i_data,
  input  logic             i_rd,
  output entry_t           o_head,
  output logic [CNT_W-1:0] o_count
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  always_comb begin
    w_head_nxt = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
    w_tail_nxt = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
  end

  // Pointer and occupancy tracking; simultaneous write and read keeps count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) r_tail <= w_tail_nxt;
      if (i_rd) r_head <= w_head_nxt;
      unique case ({i_wr, i_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; a write into a full queue lands in the slot freed by the same-edge read.
  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_wr && !i_rd && (r_count == CNT_W'(DEPTH))));

  no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_rd && (r_count == '0)));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU writeback stream and
// buffered load returns, with a pending-load scoreboard for decode hazards.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned LDQ_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_stall,
  input  logic                  ld_issue_valid,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  output logic                  ld_issue_ready,
  input  logic                  ld_ret_valid,
  input  logic [REG_ADDR_W-1:0] ld_ret_rd,
  input  logic [XLEN-1:0]       ld_ret_data,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int unsigned CNT_W = $clog2(LDQ_DEPTH + 1);
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_outstanding;
  logic [STV_W-1:0] r_starve;

  logic [CNT_W-1:0] w_count;
  entry_t           w_head;
  entry_t           w_enq_data;
  logic             w_alu_cand;
  logic             w_ld_cand;
  logic             w_issue;
  logic             w_ret_ok;
  logic             w_enq;
  logic             w_drop;
  logic             w_deq;
  grant_e           w_grant;

  load_return_fifo #(
    .entry_t (entry_t),
    .DEPTH   (LDQ_DEPTH)
  ) u_lrq (
    .i_clk   (clk),
    .i_reset (reset),
    .i_wr    (w_enq),
    .i_data  (w_enq_data),
    .i_rd    (w_deq),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_enq_data = '{rd: ld_ret_rd, data: ld_ret_data};

  // Arbitration: queued loads win when the ALU cannot write, the queue is full, or the ALU has starved them.
  always_comb begin
    w_alu_cand = alu_valid && !r_busy[alu_rd];
    w_ld_cand  = (w_count != '0);
    w_grant    = GNT_NONE;
    if (!reset) begin
      if (w_ld_cand && (!w_alu_cand || (w_count == CNT_W'(LDQ_DEPTH)) ||
                        (r_starve == STV_W'(STARVE_MAX)))) begin
        w_grant = GNT_LOAD;
      end else if (w_alu_cand) begin
        w_grant = GNT_ALU;
      end
    end
  end

  // Write-port mux and handshake/hazard outputs, all forced quiet during reset.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (w_grant)
      GNT_LOAD: begin
        rf_we    = 1'b1;
        rf_waddr = w_head.rd;
        rf_wdata = w_head.data;
      end
      GNT_ALU: begin
        rf_we    = (alu_rd != '0);
        rf_waddr = alu_rd;
        rf_wdata = alu_data;
      end
      default: ;
    endcase
    alu_stall      = !reset && alu_valid && (w_grant != GNT_ALU);
    ld_issue_ready = !reset && (r_outstanding < CNT_W'(LDQ_DEPTH)) && !r_busy[ld_issue_rd];
    hazard         = !reset && (r_busy[rs1] || r_busy[rs2]);
  end

  // Event decode; a return with nothing left in flight is ignored, which also bounds the queue.
  always_comb begin
    w_issue  = ld_issue_valid && ld_issue_ready;
    w_ret_ok = !reset && ld_ret_valid && (r_outstanding > w_count);
    w_enq    = w_ret_ok && (ld_ret_rd != '0);
    w_drop   = w_ret_ok && (ld_ret_rd == '0);
    w_deq    = (w_grant == GNT_LOAD);
  end

  // Credit counter: loads issued but not yet written (or dropped as x0 returns).
  always_ff @(posedge clk) begin
    if (reset) r_outstanding <= '0;
    else r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_deq) - CNT_W'(w_drop);
  end

  // Pending-load scoreboard; x0 is never marked busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_issue && (ld_issue_rd != '0)) r_busy[ld_issue_rd] <= 1'b1;
      if (w_deq && (w_head.rd != '0))     r_busy[w_head.rd]   <= 1'b0;
    end
  end

  // Starvation counter: consecutive ALU wins while a load waits in the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else begin
      unique case (w_grant)
        GNT_ALU: r_starve <= w_ld_cand ? r_starve + 1'b1 : '0;
        default: r_starve <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench with a queue-based reference model and a scoreboard monitor.
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;
  logic            ld_issue_valid;
  logic [4:0]      ld_issue_rd;
  logic            ld_issue_ready;
  logic            ld_ret_valid;
  logic [4:0]      ld_ret_rd;
  logic [XLEN-1:0] ld_ret_data;
  logic [4:0]      rs1, rs2;
  logic            hazard;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN       (XLEN),
    .LDQ_DEPTH  (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_stall      (alu_stall),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_ret_valid   (ld_ret_valid),
    .ld_ret_rd      (ld_ret_rd),
    .ld_ret_data    (ld_ret_data),
    .rs1            (rs1),
    .rs2            (rs2),
    .hazard         (hazard),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    int              due;
  } mem_t;

  typedef struct {
    bit              we;
    logic [4:0]      a;
    logic [XLEN-1:0] d;
    bit              stall;
    bit              ready;
    bit              hazard;
  } exp_t;

  // Reference state: busy set, load queue, credits, starvation, plus stimulus sources.
  bit   m_busy [32];
  ent_t m_ldq [$];
  int   m_out;
  int   m_starve;
  mem_t mem_q [$];
  ent_t alu_q [$];
  exp_t exp_q [$];
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_ldq.delete();
    mem_q.delete();
    alu_q.delete();
    m_out    = 0;
    m_starve = 0;
  endtask

  // One cycle: drive inputs, predict outputs from the model, advance the model.
  task automatic step(input bit rst = 0, input bit iss = 0, input logic [4:0] ird = 0,
                      input int lat = 1, input logic [4:0] s1 = 0, input logic [4:0] s2 = 0);
    exp_t e;
    bit   a_c, l_c, lw, aw, rdy;
    mem_t r;
    @(posedge clk);
    #1;
    reset          = rst;
    alu_valid      = !rst && (alu_q.size() > 0);
    alu_rd         = alu_valid ? alu_q[0].rd : 5'($urandom);
    alu_data       = alu_valid ? alu_q[0].data : $urandom;
    ld_issue_valid = iss;
    ld_issue_rd    = ird;
    ld_ret_valid   = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    ld_ret_rd      = ld_ret_valid ? mem_q[0].rd : 5'($urandom);
    ld_ret_data    = ld_ret_valid ? mem_q[0].data : $urandom;
    rs1            = s1;
    rs2            = s2;
    e = '{we: 0, a: '0, d: '0, stall: 0, ready: 0, hazard: 0};
    if (rst) begin
      model_reset();
    end else begin
      a_c = alu_valid && !m_busy[alu_rd];
      l_c = (m_ldq.size() != 0);
      lw  = l_c && (!a_c || (m_ldq.size() == DEPTH) || (m_starve == SMAX));
      aw  = a_c && !lw;
      rdy = (m_out < DEPTH) && !m_busy[ird];
      e.ready  = rdy;
      e.hazard = m_busy[s1] || m_busy[s2];
      e.stall  = alu_valid && !aw;
      if (lw) begin
        e.we = 1;
        e.a  = m_ldq[0].rd;
        e.d  = m_ldq[0].data;
        m_busy[m_ldq[0].rd] = 1'b0;
        void'(m_ldq.pop_front());
        m_out--;
        m_starve = 0;
      end else if (aw) begin
        e.we = (alu_rd != 0);
        e.a  = alu_rd;
        e.d  = alu_data;
        m_starve = l_c ? m_starve + 1 : 0;
        void'(alu_q.pop_front());
      end else begin
        m_starve = 0;
      end
      if (ld_ret_valid) begin
        r = mem_q.pop_front();
        if (r.rd == 0) m_out--;
        else m_ldq.push_back('{rd: r.rd, data: r.data});
      end
      if (iss && rdy) begin
        m_out++;
        if (ird != 0) m_busy[ird] = 1'b1;
        mem_q.push_back('{rd: ird, data: $urandom, due: cyc + lat});
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  // Monitor: pops the expectation for each cycle and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", rf_we, e.we);
        if (e.we) begin
          chk("rf_waddr", rf_waddr, e.a);
          chk("rf_wdata", rf_wdata, e.d);
        end
        chk("alu_stall", alu_stall, e.stall);
        chk("ld_issue_ready", ld_issue_ready, e.ready);
        chk("hazard", hazard, e.hazard);
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_ret_valid = 0; ld_ret_rd = 0; ld_ret_data = 0;
    rs1 = 0; rs2 = 0;
    model_reset();
    repeat (3) step(1);

    // Idle ALU stream.
    alu_q.push_back('{rd: 5, data: 32'h1234});
    step();
    step();

    // Load round trip to x7, return 3 cycles after issue, rs1 watching x7.
    step(0, 1, 7, 3, 7, 0);
    repeat (6) step(0, 0, 0, 1, 7, 0);

    // Credit limit with two loads in flight.
    step(0, 1, 1, 3, 1, 2);
    step(0, 1, 2, 3, 1, 2);
    repeat (6) step(0, 1, 4, 20, 1, 2);
    repeat (25) step();

    // Queue full while the ALU keeps presenting x3.
    for (int i = 0; i < 8; i++) alu_q.push_back('{rd: 3, data: 32'hA000 + i});
    step(0, 1, 1, 2);
    step(0, 1, 2, 2);
    repeat (10) step();

    // Starvation: one queued load against continuous ALU traffic.
    for (int i = 0; i < 10; i++) alu_q.push_back('{rd: 3, data: 32'hB000 + i});
    step(0, 1, 9, 1, 9, 0);
    repeat (12) step(0, 0, 0, 1, 9, 0);

    // WAW: ALU targets a register with a pending load.
    step(0, 1, 7, 4, 7, 0);
    alu_q.push_back('{rd: 7, data: 32'hC0DE});
    repeat (8) step(0, 0, 0, 1, 7, 0);

    // Load to x0 and ALU write to x0.
    step(0, 1, 0, 2);
    alu_q.push_back('{rd: 0, data: 32'hFFFF});
    repeat (4) step(0, 1, 0, 2);
    repeat (4) step();

    // Reset with two loads outstanding.
    step(0, 1, 1, 10, 1, 2);
    step(0, 1, 2, 10, 1, 2);
    step(0, 0, 0, 1, 1, 2);
    step(1, 1, 1, 1, 1, 2);
    step(1, 0, 1, 1, 1, 2);
    repeat (3) step(0, 0, 1, 1, 1, 2);

    // Randomised traffic with small register range to provoke hazards and WAW.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1);
      end else begin
        if ((alu_q.size() == 0) && ($urandom_range(0, 2) != 0))
          alu_q.push_back('{rd: 5'($urandom_range(0, 7)), data: $urandom});
        step(0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
             $urandom_range(1, 5), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end

    guard = 0;
    while (((alu_q.size() + mem_q.size() + m_ldq.size()) != 0) && (guard < 100)) begin
      step();
      guard++;
    end
    chk("drain_bound", guard < 100, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
